// File: rtl/pwm_gen.sv
// pwm_gen: turns the value of a free-running N-bit counter into a PWM waveform.
// The period is 2^N clocks and starts where the counter wraps to zero. A new
// duty value is accepted into a shadow register through a valid/ready handshake,
// and it only takes effect at a period boundary, so no period is ever cut short.
// A four-state FSM handles run/stop. A stop request always lets the current
// period finish before the output goes idle.
// Optional build macro: PWM_PERIOD_IRQ_EN adds a sticky period interrupt
// (ports irq_clr / irq).
module pwm_gen #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] cnt,
    input  logic         enable,
    input  logic [N:0]   duty_in,
    input  logic         duty_valid,
    output logic         duty_ready,
    output logic         pwm_out,
    output logic         period_start,
`ifdef PWM_PERIOD_IRQ_EN
    input  logic         irq_clr,
    output logic         irq,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [N:0] active_duty_q, active_duty_d;
    logic [N:0] shadow_q, shadow_d;
    logic       shadow_full_q, shadow_full_d;
    logic       pwm_q, pwm_d;
    logic       period_start_q, period_start_d;

    logic       boundary;
    logic       run_next;
    logic       accept;
    logic       load;
    logic [N:0] duty_eff;

    assign boundary = (cnt == '0);

    // Next-state logic for run/stop. When DRAIN reaches a boundary, the
    // boundary wins over a fresh enable.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = ARMED;
            end
            ARMED: begin
                if (boundary)     state_d = RUN;
                else if (!enable) state_d = IDLE;
            end
            RUN: begin
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (boundary)    state_d = IDLE;
                else if (enable) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    assign run_next = (state_d == RUN) || (state_d == DRAIN);

    // Shadow handshake, duty transfer at the boundary, and the compare.
    // Accept and load never coincide: accept needs an empty shadow, and load
    // needs a full one.
    always_comb begin
        accept         = duty_valid & ~shadow_full_q;
        load           = boundary & shadow_full_q & run_next;
        shadow_d       = shadow_q;
        shadow_full_d  = shadow_full_q;
        active_duty_d  = active_duty_q;
        if (accept) begin
            shadow_d      = duty_in;
            shadow_full_d = 1'b1;
        end
        if (load) begin
            active_duty_d = shadow_q;
            shadow_full_d = 1'b0;
        end
        duty_eff       = load ? shadow_q : active_duty_q;
        pwm_d          = run_next & ({1'b0, cnt} < duty_eff);
        period_start_d = boundary & run_next;
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Duty registers and the registered waveform outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active_duty_q  <= '0;
            shadow_q       <= '0;
            shadow_full_q  <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            active_duty_q  <= active_duty_d;
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

`ifdef PWM_PERIOD_IRQ_EN
    logic irq_q, irq_d;

    // Sticky period flag. It rises together with period_start, and a set wins
    // over a clear in the same cycle.
    always_comb begin
        irq_d = period_start_d | (irq_q & ~irq_clr);
    end

    // Interrupt flag register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

    assign duty_ready   = ~shadow_full_q;
    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: self-checking bench for pwm_gen with N=4 (16-clock period).
// The bench drives the counter value itself, so it can also make the counter
// jump. It tracks expected behaviour at the period level: whether a period is
// running, whether a stop is pending, the pending and applied duty values, and
// the output expected from a plain arithmetic compare.
module tb_pwm_gen;

    localparam int N = 4;

    logic         clock;
    logic         reset_n;
    logic [N-1:0] cnt;
    logic         enable;
    logic [N:0]   duty_in;
    logic         duty_valid;
    logic         duty_ready;
    logic         pwm_out;
    logic         period_start;
    logic         busy;
`ifdef PWM_PERIOD_IRQ_EN
    logic         irq_clr;
    logic         irq;
    bit           m_irq;
`endif

    int errors = 0;
    int checks = 0;

    // Reference state, kept at the period level.
    bit          m_armed, m_running, m_stop, m_full;
    int unsigned m_pend, m_duty;

    pwm_gen #(.N(N)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cnt          (cnt),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
`ifdef PWM_PERIOD_IRQ_EN
        .irq_clr      (irq_clr),
        .irq          (irq),
`endif
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_armed = 0; m_running = 0; m_stop = 0; m_full = 0;
        m_pend = 0; m_duty = 0;
`ifdef PWM_PERIOD_IRQ_EN
        m_irq = 0;
`endif
    endtask

    // One clock. The expected values come from the inputs sampled before the
    // edge. The outputs are checked 1 time unit after the edge, and then the
    // counter advances. The duty source drops valid once its value is taken.
    task automatic tick();
        bit b, acc, runs, load, n_arm, e_pwm, e_ps, e_busy, e_ready;
        int unsigned eff;
        b   = (cnt == 0);
        acc = duty_valid && !m_full;
        if (m_running) runs = b ? !m_stop : 1'b1;
        else           runs = b && m_armed;
        n_arm = !runs && enable && !m_running;
        load  = b && m_full && runs;
        eff   = load ? m_pend : m_duty;
        e_pwm = runs && (32'(cnt) < eff);
        e_ps  = b && runs;
        if (load) begin
            m_duty = m_pend;
            m_full = 0;
        end
        if (acc) begin
            m_pend = 32'(duty_in);
            m_full = 1;
        end
        m_stop    = runs && !enable;
        m_running = runs;
        m_armed   = n_arm;
`ifdef PWM_PERIOD_IRQ_EN
        m_irq = e_ps || (m_irq && !irq_clr);
`endif
        e_busy  = m_armed || m_running;
        e_ready = !m_full;
        @(posedge clock);
        #1;
        checks++;
        if (pwm_out !== e_pwm) begin
            errors++;
            $display("FAIL pwm_out t=%0t cnt_prev=%0d: got %b expected %b", $time, cnt, pwm_out, e_pwm);
        end
        checks++;
        if (period_start !== e_ps) begin
            errors++;
            $display("FAIL period_start t=%0t: got %b expected %b", $time, period_start, e_ps);
        end
        checks++;
        if (busy !== e_busy) begin
            errors++;
            $display("FAIL busy t=%0t: got %b expected %b", $time, busy, e_busy);
        end
        checks++;
        if (duty_ready !== e_ready) begin
            errors++;
            $display("FAIL duty_ready t=%0t: got %b expected %b", $time, duty_ready, e_ready);
        end
`ifdef PWM_PERIOD_IRQ_EN
        checks++;
        if (irq !== m_irq) begin
            errors++;
            $display("FAIL irq t=%0t: got %b expected %b", $time, irq, m_irq);
        end
`endif
        if (acc) duty_valid = 1'b0;
        cnt = cnt + 1'b1;
    endtask

    // Advance until the next counter value to be sampled equals v.
    task automatic advance_to(input int v);
        int k = 0;
        while (32'(cnt) != v && k < 20) begin
            tick();
            k++;
        end
    endtask

    // Wait (bounded) for period_start, then add up pwm_out over that period.
    task automatic count_period(output int highs, output int waited);
        bit found = 0;
        highs  = 0;
        waited = 0;
        while (!found && waited < 40) begin
            tick();
            waited++;
            if (period_start === 1'b1) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL period_wait: no period_start within %0d clocks", waited);
        end
        highs = (pwm_out === 1'b1) ? 1 : 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (pwm_out === 1'b1) highs++;
        end
    endtask

    task automatic load_duty(input int d);
        duty_in    = 5'(d);
        duty_valid = 1'b1;
        tick();
    endtask

    // Reset in the middle of a cycle. The outputs must drop at once, without
    // waiting for a clock edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (pwm_out !== 1'b0 || period_start !== 1'b0 || busy !== 1'b0 || duty_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: pwm=%b ps=%b busy=%b ready=%b expected 0 0 0 1",
                     pwm_out, period_start, busy, duty_ready);
        end
`ifdef PWM_PERIOD_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_reset: got %b expected 0", irq);
        end
`endif
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        cnt = cnt + 1'b1;
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if (pwm_out !== 1'b0 || period_start !== 1'b0 || busy !== 1'b0 || duty_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: pwm=%b ps=%b busy=%b ready=%b expected 0 0 0 1",
                     pwm_out, period_start, busy, duty_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_enable_no_duty();
        int h, w;
        enable = 1'b1;
        advance_to(5);
        count_period(h, w);
        checks++;
        if (h != 0) begin errors++; $display("FAIL no_duty_high: got %0d expected 0", h); end
        count_period(h, w);
        checks++;
        if (w != 1) begin errors++; $display("FAIL period_spacing: got %0d expected 1", w); end
    endtask

    task automatic test_duty5();
        int h, w, k;
        enable = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 40) begin tick(); k++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drain_to_idle: busy got %b expected 0", busy); end
        load_duty(5);
        checks++;
        if (duty_ready !== 1'b0) begin errors++; $display("FAIL ready_after_accept: got %b expected 0", duty_ready); end
        enable = 1'b1;
        count_period(h, w);
        checks++;
        if (h != 5) begin errors++; $display("FAIL duty5_high: got %0d expected 5", h); end
        checks++;
        if (duty_ready !== 1'b1) begin errors++; $display("FAIL ready_after_load: got %b expected 1", duty_ready); end
    endtask

    task automatic test_full_zero();
        int h, w;
        advance_to(8);
        load_duty(16);
        count_period(h, w);
        checks++;
        if (h != 16) begin errors++; $display("FAIL duty16_high: got %0d expected 16", h); end
        advance_to(8);
        load_duty(0);
        count_period(h, w);
        checks++;
        if (h != 0) begin errors++; $display("FAIL duty0_high: got %0d expected 0", h); end
    endtask

    task automatic test_boundary_accept();
        int h, w;
        advance_to(0);
        load_duty(9);
        checks++;
        if (period_start !== 1'b1 || pwm_out !== 1'b0 || duty_ready !== 1'b0) begin
            errors++;
            $display("FAIL boundary_accept: ps=%b pwm=%b ready=%b expected 1 0 0", period_start, pwm_out, duty_ready);
        end
        load_duty(3);
        checks++;
        if (duty_ready !== 1'b0 || duty_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_shadow_hold: ready=%b valid=%b expected 0 1", duty_ready, duty_valid);
        end
        count_period(h, w);
        checks++;
        if (h != 9) begin errors++; $display("FAIL duty9_high: got %0d expected 9", h); end
        count_period(h, w);
        checks++;
        if (h != 3) begin errors++; $display("FAIL duty3_high: got %0d expected 3", h); end
    endtask

    task automatic test_stop_drain();
        int h, w;
        advance_to(8);
        load_duty(12);
        count_period(h, w);
        checks++;
        if (h != 12) begin errors++; $display("FAIL duty12_high: got %0d expected 12", h); end
        // Stop at cnt 3: the period still runs to the end.
        advance_to(3);
        enable = 1'b0;
        h = 0;
        for (int i = 3; i < 16; i++) begin tick(); if (pwm_out === 1'b1) h++; end
        checks++;
        if (h != 9 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_tail: highs=%0d busy=%b expected 9 1", h, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: busy=%b pwm=%b expected 0 0", busy, pwm_out);
        end
        // Going back to RUN from DRAIN keeps the current period intact.
        enable = 1'b1;
        count_period(h, w);
        advance_to(3);
        enable = 1'b0;
        h = 0;
        for (int i = 3; i < 8; i++) begin tick(); if (pwm_out === 1'b1) h++; end
        enable = 1'b1;
        for (int i = 8; i < 16; i++) begin tick(); if (pwm_out === 1'b1) h++; end
        checks++;
        if (h != 9) begin errors++; $display("FAIL resume_highs: got %0d expected 9", h); end
        tick();
        checks++;
        if (period_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL resume_continue: ps=%b busy=%b expected 1 1", period_start, busy);
        end
        // In DRAIN, a boundary together with enable goes to IDLE.
        advance_to(5);
        enable = 1'b0;
        advance_to(0);
        enable = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL drain_precedence: busy=%b ps=%b expected 0 0", busy, period_start);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rearm: busy got %b expected 1", busy); end
    endtask

    task automatic test_mid_reset();
        int h, w;
        count_period(h, w);
        advance_to(4);
        checks++;
        if (pwm_out !== 1'b1) begin errors++; $display("FAIL pre_reset_pwm: got %b expected 1", pwm_out); end
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            tick();
            if (i == 400) do_reset();
            if ($urandom_range(0, 49) == 0) cnt = 4'($urandom_range(0, 15));
            // Enable changes only in cycles that will not sample a boundary.
            if (cnt != 0 && $urandom_range(0, 19) == 0) enable = ~enable;
            if (!duty_valid && $urandom_range(0, 7) == 0) begin
                duty_in    = 5'($urandom_range(0, 31));
                duty_valid = 1'b1;
            end
`ifdef PWM_PERIOD_IRQ_EN
            irq_clr = ($urandom_range(0, 3) == 0);
`endif
        end
    endtask

`ifdef PWM_PERIOD_IRQ_EN
    task automatic test_irq();
        irq_clr = 1'b0;
        advance_to(0);
        irq_clr = 1'b1;
        tick();
        checks++;
        if (period_start !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins: ps=%b irq=%b expected 1 1", period_start, irq);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
        irq_clr = 1'b0;
    endtask
`endif

    initial begin
        reset_n    = 1'b0;
        cnt        = '0;
        enable     = 1'b0;
        duty_in    = '0;
        duty_valid = 1'b0;
`ifdef PWM_PERIOD_IRQ_EN
        irq_clr    = 1'b0;
`endif
        model_reset();
        test_reset();
        test_enable_no_duty();
        test_duty5();
        test_full_zero();
        test_boundary_accept();
        test_stop_drain();
`ifdef PWM_PERIOD_IRQ_EN
        test_irq();
`endif
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
